// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants for the register file write path.
//   REG_ADDR_W / REG_DATA_W : default register index and data widths
//   REG_ZERO                : hard-wired zero register index
//   WR_PORT_PIPE / WR_PORT_MC : requester index of the pipeline writeback
//                               port and of the multi-cycle unit port
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int WR_PORT_PIPE = 0;
    localparam int WR_PORT_MC   = 1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter with a combinational one-hot grant.
//   clk, rst : clock and asynchronous active-high reset
//   req[1:0] : request lines (bit WR_PORT_PIPE, bit WR_PORT_MC)
//   enable   : when low no grant is issued and the history holds
//   gnt[1:0] : one-hot grant, valid in the same cycle as req
// The history bit last_grant_r resets to 1 so requester 0 wins the first
// contention; it is updated to the winner on every grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic       last_grant_r;
    logic [1:0] gnt_s;

    // Grant decode: a lone requester always wins, on contention the port that
    // did not win last time is served.
    always_comb begin
        gnt_s = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11: begin
                    if (last_grant_r) begin
                        gnt_s = 2'b01;
                    end else begin
                        gnt_s = 2'b10;
                    end
                end
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign gnt = gnt_s;

    // History register: remembers the winner of the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (gnt_s[WR_PORT_PIPE]) begin
            last_grant_r <= 1'b0;
        end else if (gnt_s[WR_PORT_MC]) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the register file's single write port between the pipeline
// writeback (port 0) and the multi-cycle unit (port 1).
//   clk, rst          : clock, asynchronous active-high reset
//   freeze            : pipeline stall, blocks all new grants
//   pN_vld/pN_rdy     : valid/ready handshake, rdy is combinational
//   pN_addr/pN_data   : destination register and write data
//   rf_wr_en/addr/data: registered write controls, commit one edge after
//                       the accepting edge
//   pend_mask         : bit i set while a write to register i has been
//                       accepted but not yet committed
//   conflict_cnt      : (only with REGFILE_WR_ARB_STATS_EN defined) saturating
//                       count of unfrozen cycles with both ports valid
// Writes to register 0 are accepted but never drive rf_wr_en and never
// appear in pend_mask.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic                     p0_vld,
    output logic                     p0_rdy,
    input  logic [ADDR_W-1:0]        p0_addr,
    input  logic [DATA_W-1:0]        p0_data,
    input  logic                     p1_vld,
    output logic                     p1_rdy,
    input  logic [ADDR_W-1:0]        p1_addr,
    input  logic [DATA_W-1:0]        p1_data,
    output logic                     rf_wr_en,
    output logic [ADDR_W-1:0]        rf_wr_addr,
    output logic [DATA_W-1:0]        rf_wr_data,
    output logic [(2**ADDR_W)-1:0]   pend_mask
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]         conflict_cnt
`endif
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_nonzero_s;
    logic [NREG-1:0]   set_s;
    logic [NREG-1:0]   clr_s;
    logic [NREG-1:0]   pend_next_s;

    assign req_s = {p1_vld, p0_vld};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .enable (~freeze),
        .gnt    (gnt_s)
    );

    assign p0_rdy = gnt_s[WR_PORT_PIPE];
    assign p1_rdy = gnt_s[WR_PORT_MC];
    assign xfer_s = |gnt_s;

    // Winning request mux; port 0 is the don't-care default when idle.
    always_comb begin
        sel_addr_s = p0_addr;
        sel_data_s = p0_data;
        if (gnt_s[WR_PORT_MC]) begin
            sel_addr_s = p1_addr;
            sel_data_s = p1_data;
        end else begin
            sel_addr_s = p0_addr;
            sel_data_s = p0_data;
        end
    end

    assign sel_nonzero_s = (sel_addr_s != ADDR_W'(REG_ZERO));

    // Scoreboard update: the commit clears its bit, a new accepted write sets
    // its bit, and set is applied last so it wins on the same register.
    always_comb begin
        set_s = {NREG{1'b0}};
        clr_s = {NREG{1'b0}};
        if (xfer_s && sel_nonzero_s) begin
            set_s = {{(NREG-1){1'b0}}, 1'b1} << sel_addr_s;
        end else begin
            set_s = {NREG{1'b0}};
        end
        if (rf_wr_en) begin
            clr_s = {{(NREG-1){1'b0}}, 1'b1} << rf_wr_addr;
        end else begin
            clr_s = {NREG{1'b0}};
        end
        pend_next_s = (pend_mask & ~clr_s) | set_s;
    end

    // Output stage: reloads every cycle; address and data hold when idle so
    // the register file inputs do not toggle needlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= {ADDR_W{1'b0}};
            rf_wr_data <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            rf_wr_en   <= sel_nonzero_s;
            rf_wr_addr <= sel_addr_s;
            rf_wr_data <= sel_data_s;
        end else begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= rf_wr_addr;
            rf_wr_data <= rf_wr_data;
        end
    end

    // Pending-write scoreboard register consumed by the hazard unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_mask <= {NREG{1'b0}};
        end else begin
            pend_mask <= pend_next_s;
        end
    end

`ifdef REGFILE_WR_ARB_STATS_EN
    logic conflict_s;

    assign conflict_s = p0_vld & p1_vld & ~freeze;

    // Saturating contention counter; frozen cycles are not contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= {CNT_W{1'b0}};
        end else if (conflict_s && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            conflict_cnt <= conflict_cnt;
        end
    end
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Arbitrates the register file's single write port between two writeback requesters: port 0 for pipeline writeback and port 1 for the multi-cycle unit (mult/div, load return). It uses a valid/ready handshake, round-robin on contention, and a registered output stage that drives the register file write controls. It also maintains a 32-bit pending-write scoreboard that the hazard unit consumes.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (2**ADDR_W registers)
CNT_W, 16, conflict counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
freeze  in  1  pipeline stall; blocks all new grants
p0_vld  in  1  port 0 write request valid
p0_rdy  out  1  port 0 accepted this cycle
p0_addr  in  ADDR_W  port 0 destination register
p0_data  in  DATA_W  port 0 write data
p1_vld  in  1  port 1 write request valid
p1_rdy  out  1  port 1 accepted this cycle
p1_addr  in  ADDR_W  port 1 destination register
p1_data  in  DATA_W  port 1 write data
rf_wr_en  out  1  register file write enable
rf_wr_addr  out  ADDR_W  register file write index
rf_wr_data  out  DATA_W  register file write data
pend_mask  out  2**ADDR_W  bit i = write to register i accepted but not yet committed

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-high.
- On reset:
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, pend_mask=0.
  - last_grant=1, so port 0 wins the first contention.
- pN_rdy is combinational from pN_vld, freeze and last_grant. A transfer occurs when pN_vld && pN_rdy. At most one transfer per cycle.
- Grant rules:
  - freeze=1: both rdy=0.
  - Only one port valid: that port gets rdy=1.
  - Both valid: the port not equal to last_grant gets rdy=1. last_grant updates to the winner on every transfer.
  - No transfer: last_grant holds.
- A requester holds vld/addr/data stable until rdy; the arbiter does not buffer unaccepted requests.
- Latency:
  - Transfer at edge N: rf_wr_en/addr/data are driven during cycle N..N+1, and the register file commits at edge N+1.
  - Output stage reloads every cycle. No transfer: rf_wr_en=0, and addr/data hold their previous values.
- Register 0: transfer is accepted (rdy=1) but rf_wr_en stays 0 and the pend_mask bit is never set.
- Scoreboard:
  - Bit a sets at the edge of an accepted transfer with non-zero addr a.
  - Bit a clears at the edge where rf_wr_en=1 with rf_wr_addr=a.
  - Same edge sets and clears the same bit: set wins, so the bit stays 1.
- Same-address ordering: commits occur in grant order, so the later grant's data is the final register value.
- freeze does not cancel an already-registered output write; that write commits normally.
- Reset asserted mid-operation discards the registered write (no commit) and clears the scoreboard.

Optional Feature:
REGFILE_WR_ARB_STATS_EN
- Defined:
  - Adds output port conflict_cnt [CNT_W-1:0], reset to 0.
  - Increments by 1 on every cycle where p0_vld=1, p1_vld=1 and freeze=0.
  - Saturates at all-ones.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0
  - port index constants WR_PORT_PIPE=0, WR_PORT_MC=1
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Inputs: req[1:0], enable (=!freeze).
  - Outputs: one-hot gnt[1:0].
  - Internal last_grant register, async active-high reset to 1.
- Top level: output stage, zero-address filter, scoreboard, optional counter.

Test Plan:
- Reset → all outputs 0. Then p0_vld=1, addr=3, data=32'hDEADBEEF:
  - p0_rdy=1 the same cycle.
  - Next cycle: rf_wr_en=1, rf_wr_addr=3, rf_wr_data=DEADBEEF, pend_mask[3]=1.
  - pend_mask[3]=0 one cycle later.
- p0 and p1 both valid for 4 cycles (each re-presents a new request after acceptance) → grants go p0,p1,p0,p1; rf_wr_addr follows the same order.
- p1 write to addr 0, data 32'h1234 → p1_rdy=1, rf_wr_en stays 0, pend_mask unchanged.
- freeze=1 with both valid for 3 cycles → both rdy=0, rf_wr_en=0 from the second cycle. A write registered before freeze still commits.
- Back-to-back p0 writes to addr 7 (data 1, then 2) → two commits in order, pend_mask[7] stays 1 across the overlap edge, register 7 ends at 2.
- Assert rst while rf_wr_en=1, addr=5 → rf_wr_en drops immediately, pend_mask=0. With REGFILE_WR_ARB_STATS_EN defined, conflict_cnt=0 after reset and equals 4 after the contention scenario.
